s2_conv_scheduler: RTL and testbench

//  Sequences the stage-2 3x3x3 convolution datapath over every (filter, output row, output col) point.

---
 rtl/s2_conv_scheduler.sv | 142 ++++++++++++++
 tb/tb_s2_conv_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/s2_conv_scheduler.sv
// Stage-2 convolution scheduler: walks every (filter, row, col) point one per cycle
// and replays each point's result-buffer address DP_LAT cycles later as a write strobe.
module s2_conv_scheduler #(
    parameter int N_FILT   = 4,
    parameter int OUT_ROWS = 6,
    parameter int OUT_COLS = 6,
    parameter int DP_LAT   = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       hold_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       proc_valid_o,
    output logic [1:0] proc_dir_o,
    output logic [2:0] proc_row_o,
    output logic [2:0] proc_col_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       vld_q, vld_d;
    logic [7:0] addr_q, addr_d;
    logic       in_flight;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        row_d   = row_q;
        col_d   = col_q;
        vld_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    dir_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    vld_d   = 1'b1;
                end
            end
            RUN: begin
                if (!hold_i) begin
                    vld_d = 1'b1;
                    if (col_q == 3'(OUT_COLS - 1)) begin
                        col_d = '0;
                        if (row_q == 3'(OUT_ROWS - 1)) begin
                            row_d = '0;
                            dir_d = dir_q + 2'd1;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                    // Leave RUN on the edge that issues the final point.
                    if (dir_d == 2'(N_FILT - 1) && row_d == 3'(OUT_ROWS - 1) &&
                        col_d == 3'(OUT_COLS - 1))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        addr_d = 8'(dir_d) * 8'(OUT_ROWS * OUT_COLS) + 8'(row_d) * 8'(OUT_COLS) + 8'(col_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dir_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            vld_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            row_q   <= row_d;
            col_q   <= col_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
        end
    end

    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);
    assign proc_valid_o = vld_q;
    assign proc_dir_o   = dir_q;
    assign proc_row_o   = row_q;
    assign proc_col_o   = col_q;

    generate
        if (DP_LAT == 0) begin : g_nodly
            assign wr_en_o   = vld_q;
            assign wr_addr_o = vld_q ? addr_q : '0;
            assign in_flight = 1'b0;
        end else begin : g_dly
            logic [DP_LAT-1:0]       tok_vld_q;
            logic [DP_LAT-1:0][7:0]  tok_addr_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    tok_vld_q  <= '0;
                    tok_addr_q <= '0;
                end else begin
                    tok_vld_q[0]  <= vld_q;
                    tok_addr_q[0] <= vld_q ? addr_q : '0;
                    for (int i = 1; i < DP_LAT; i++) begin
                        tok_vld_q[i]  <= tok_vld_q[i-1];
                        tok_addr_q[i] <= tok_addr_q[i-1];
                    end
                end
            end

            // The output stage is being written this cycle, so it does not hold DRAIN open.
            always_comb begin
                in_flight = vld_q;
                for (int i = 0; i < DP_LAT - 1; i++)
                    in_flight = in_flight | tok_vld_q[i];
            end

            assign wr_en_o   = tok_vld_q[DP_LAT-1];
            assign wr_addr_o = tok_addr_q[DP_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_s2_conv_scheduler.sv
// Directed bench for s2_conv_scheduler: DP_LAT=1 main instance plus DP_LAT=0/3 builds on shared stimulus.
module tb_s2_conv_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic       busy, done, pv, wr_en;
    logic [1:0] dir;
    logic [2:0] row, col;
    logic [7:0] wr_addr;
    logic       busy0, done0, pv0, wr_en0;
    logic [1:0] dir0;
    logic [2:0] row0, col0;
    logic [7:0] wr_addr0;
    logic       busy3, done3, pv3, wr_en3;
    logic [1:0] dir3;
    logic [2:0] row3, col3;
    logic [7:0] wr_addr3;

    always #5 clk = ~clk;

    s2_conv_scheduler #(.DP_LAT(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hold_i(hold),
        .busy_o(busy), .done_o(done), .proc_valid_o(pv), .proc_dir_o(dir),
        .proc_row_o(row), .proc_col_o(col), .wr_en_o(wr_en), .wr_addr_o(wr_addr));

    s2_conv_scheduler #(.DP_LAT(0)) u_lat0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hold_i(hold),
        .busy_o(busy0), .done_o(done0), .proc_valid_o(pv0), .proc_dir_o(dir0),
        .proc_row_o(row0), .proc_col_o(col0), .wr_en_o(wr_en0), .wr_addr_o(wr_addr0));

    s2_conv_scheduler #(.DP_LAT(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hold_i(hold),
        .busy_o(busy3), .done_o(done3), .proc_valid_o(pv3), .proc_dir_o(dir3),
        .proc_row_o(row3), .proc_col_o(col3), .wr_en_o(wr_en3), .wr_addr_o(wr_addr3));

    localparam int NPTS = 144;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    // Reference model state
    bit m_idle = 1'b1;
    int m_iss = 0;
    int m_last = -100;
    bit exp_pv = 1'b0;
    int exp_idx = 0;
    bit h_v[3];
    int h_a[3];

    // Per-pass observations
    int base, first_pv, last_pv, pv_cnt, wr_cnt, done_cnt, done_cyc, done0_cyc, done3_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        bit exp_busy;
        chk("proc_valid", pv, exp_pv);
        if (exp_pv) begin
            chk("issue_dir", dir, exp_idx / 36);
            chk("issue_row", row, (exp_idx % 36) / 6);
            chk("issue_col", col, exp_idx % 6);
        end else if (m_iss > 0) begin
            chk("frozen_row", row, ((m_iss - 1) % 36) / 6);
            chk("frozen_col", col, (m_iss - 1) % 6);
        end
        exp_busy = !m_idle && !(m_iss == NPTS && cyc >= m_last + 2);
        chk("busy", busy, exp_busy);
        chk("done", done, m_iss == NPTS && cyc == m_last + 2);
        chk("lat0_done", done0, m_iss == NPTS && cyc == m_last + 1);
        chk("lat3_done", done3, m_iss == NPTS && cyc == m_last + 4);
        chk("wr_en", wr_en, h_v[0]);
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("wr_unexpected", wr_en, 0);
            else chk("wr_addr", wr_addr, exp_q.pop_front());
        end else begin
            chk("wr_addr_idle", wr_addr, 0);
        end
        chk("lat0_wr_en", wr_en0, exp_pv);
        chk("lat0_wr_addr", wr_addr0, exp_pv ? exp_idx : 0);
        chk("lat3_wr_en", wr_en3, h_v[2]);
        chk("lat3_wr_addr", wr_addr3, h_a[2]);
        h_v[2] = h_v[1]; h_a[2] = h_a[1];
        h_v[1] = h_v[0]; h_a[1] = h_a[0];
        h_v[0] = exp_pv; h_a[0] = exp_pv ? exp_idx : 0;
        if (pv) begin
            if (first_pv < 0) first_pv = cyc;
            last_pv = cyc;
            pv_cnt++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (done0) done0_cyc = cyc;
        if (done3) done3_cyc = cyc;
    endtask

    task automatic step();
        bit nxt;
        nxt = m_idle ? start : (m_iss > 0 && m_iss < NPTS && !hold);
        if (rst) nxt = 1'b0;
        if (m_idle && start && !rst) begin
            m_idle = 1'b0;
            m_iss = 0;
            for (int i = 0; i < NPTS; i++) exp_q.push_back(8'(i));
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_pv = nxt;
        if (nxt) begin
            exp_idx = m_iss;
            m_iss++;
            if (m_iss == NPTS) m_last = cyc;
        end
        monitor();
        if (!m_idle && m_iss == NPTS && cyc == m_last + 3) m_idle = 1'b1;
    endtask

    task automatic new_pass();
        base = cyc; first_pv = -1; last_pv = -1; pv_cnt = 0; wr_cnt = 0;
        done_cnt = 0; done_cyc = -1; done0_cyc = -1; done3_cyc = -1;
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_iss = 0; m_last = -100; exp_pv = 1'b0;
        for (int i = 0; i < 3; i++) begin h_v[i] = 1'b0; h_a[i] = 0; end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        model_reset();
        new_pass();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pv", pv, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_dir_row_col", {dir, row, col}, 0);
        step(); step();
        rst = 1'b0;
        repeat (3) step();

        // Full pass with a stray start at cycle 50, plus issue-order spot checks
        new_pass();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - base < 160) begin
            if (cyc - base == 7)   chk("t2_pt7", {dir, row, col}, {2'd0, 3'd1, 3'd0});
            if (cyc - base == 37)  chk("t2_pt37", {dir, row, col}, {2'd1, 3'd0, 3'd0});
            if (cyc - base == 144) chk("t2_pt144", {dir, row, col}, {2'd3, 3'd5, 3'd5});
            if (cyc - base == 100) chk("t4_busy_mid", busy, 1);
            start = (cyc - base == 50);
            step();
        end
        start = 1'b0;
        chk("t1_first_pv", first_pv - base, 1);
        chk("t1_last_pv", last_pv - base, 144);
        chk("t1_pv_cnt", pv_cnt, NPTS);
        chk("t1_wr_cnt", wr_cnt, NPTS);
        chk("t1_done_cyc", done_cyc - base, 146);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t1_queue_left", exp_q.size(), 0);
        chk("t6_lat0_done", done0_cyc - first_pv, 144);
        chk("t6_lat3_done", done3_cyc - first_pv, 147);
        repeat (5) step();

        // Hold sampled on the edges opening cycles 10..14
        new_pass();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - base < 165) begin
            if (cyc - base == 12) begin
                chk("t3_hold_pv", pv, 0);
                chk("t3_hold_col", col, 2);
            end
            hold = (cyc - base >= 9 && cyc - base <= 13);
            step();
        end
        hold = 1'b0;
        chk("t3_pv_cnt", pv_cnt, NPTS);
        chk("t3_wr_cnt", wr_cnt, NPTS);
        chk("t3_done_cyc", done_cyc - base, 151);
        chk("t3_queue_left", exp_q.size(), 0);
        repeat (5) step();

        // Reset in the middle of a pass
        new_pass();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - base < 70) step();
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_pv", pv, 0);
        chk("t5_wr_en", wr_en, 0);
        chk("t5_done", done, 0);
        chk("t5_lat3_wr_en", wr_en3, 0);
        model_reset();
        step(); step();
        rst = 1'b0;
        new_pass();
        repeat (10) step();
        chk("t5_no_wr_after_rst", wr_cnt, 0);
        chk("t5_no_done_after_rst", done_cnt, 0);

        // Restart after reset begins again at address 0
        new_pass();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - base < 160) step();
        chk("t5_restart_pv_cnt", pv_cnt, NPTS);
        chk("t5_restart_wr_cnt", wr_cnt, NPTS);
        chk("t5_restart_done", done_cyc - base, 146);
        chk("t5_restart_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
